viterbi_chan_err_ctrl: RTL

Channel error-injection controller between encoder2 and decoder in the Viterbi tx/rx path. Registers each encoder symbol and forwards it to the decoder. Within a run window of MAX_WORDS symbols, it schedules burst errors from an LFSR trigger or a manual request, enforces a guard gap between bursts, and keeps corruption statistics. It replaces the ad-hoc inline injection logic so runs are repeatable and bounded.

---
 rtl/viterbi_chan_err_ctrl_pkg.sv | 22 ++
 rtl/viterbi_chan_err_ctrl_lfsr.sv | 35 +++
 rtl/viterbi_chan_err_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/viterbi_chan_err_ctrl_pkg.sv
// Shared types, constants and small arithmetic helpers for the Viterbi channel
// error-injection controller.
package viterbi_chan_pkg;

  typedef enum logic [2:0] {IDLE, WATCH, BURST, GUARD, DONE} chan_state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int unsigned CNT_W     = 16;

  // Add a 0..2 increment to a counter, clamping at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W - 1){1'b0}}, inc};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  function automatic logic [1:0] popcount2(input logic [1:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]};
  endfunction

endpackage

// File: rtl/viterbi_chan_err_ctrl_lfsr.sv
// 16-bit right-shifting Galois LFSR with synchronous load and step enable.
module chan_lfsr16
  import viterbi_chan_pkg::*;
#(
  parameter logic [15:0] RST_VAL = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  output logic [15:0] state_o
);

  logic [15:0] r_state;
  logic [15:0] w_next;

  always_comb begin
    w_next = {1'b0, r_state[15:1]} ^ (r_state[0] ? LFSR_TAPS : 16'h0000);
  end

  // Load wins over step so a new run always begins from the seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RST_VAL;
    end else if (load_i) begin
      r_state <= seed_i;
    end else if (en_i) begin
      r_state <= w_next;
    end
  end

  assign state_o = r_state;

endmodule

// File: rtl/viterbi_chan_err_ctrl.sv
// Channel error-injection controller: registers encoder symbols towards the decoder and
// corrupts bounded, guard-separated bursts within a fixed-length run window.
module viterbi_chan_err_ctrl
  import viterbi_chan_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned BURST_LEN = 2,
  parameter int unsigned GAP_LEN   = 3,
  parameter int unsigned MAX_WORDS = 256,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       err_mask_i,
  input  logic             inj_req_i,
  input  logic             enc_valid_i,
  input  logic [1:0]       enc_sym_i,
  output logic             dec_enable_o,
  output logic [1:0]       dec_sym_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             inj_active_o,
  output logic [CNT_W-1:0] word_ct_o,
  output logic [CNT_W-1:0] burst_ct_o,
  output logic [CNT_W-1:0] bad_bit_ct_o
);

  localparam logic [15:0]      TRIG_MASK  = 16'((32'd1 << N) - 32'd1);
  localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(MAX_WORDS - 1);
  localparam logic [CNT_W-1:0] BURST_INIT = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_INIT   = CNT_W'(GAP_LEN);

  chan_state_t      r_state, w_state_next;
  logic [1:0]       r_mask;
  logic [15:0]      w_lfsr;
  logic [CNT_W-1:0] r_word_ct, r_burst_ct, r_bad_ct;
  logic [CNT_W-1:0] r_burst_left, r_gap_left;
  logic             r_dec_en, r_inj;
  logic [1:0]       r_dec_sym;
  logic             w_start, w_active, w_step, w_trig, w_corrupt, w_last_word;

  chan_lfsr16 #(
    .RST_VAL(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .en_i   (w_step),
    .load_i (w_start),
    .seed_i (LFSR_SEED),
    .state_o(w_lfsr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start_i) w_state_next = WATCH;
      end
      WATCH: begin
        if (w_step && w_trig) begin
          if (BURST_LEN > 1)    w_state_next = BURST;
          else if (GAP_LEN > 0) w_state_next = GUARD;
        end
      end
      BURST: begin
        if (w_step && r_burst_left == CNT_W'(1)) begin
          w_state_next = (GAP_LEN > 0) ? GUARD : WATCH;
        end
      end
      GUARD: begin
        if (w_step && r_gap_left == CNT_W'(1)) w_state_next = WATCH;
      end
      default: w_state_next = IDLE;
    endcase
    // The window end truncates whatever burst or guard is in progress.
    if (w_step && w_last_word) w_state_next = DONE;
  end

  always_comb begin
    w_active    = (r_state == WATCH) || (r_state == BURST) || (r_state == GUARD);
    w_start     = start_i && ((r_state == IDLE) || (r_state == DONE));
    w_step      = w_active && enc_valid_i;
    w_trig      = (r_state == WATCH) && (inj_req_i || ((w_lfsr & TRIG_MASK) == TRIG_MASK));
    w_corrupt   = enc_valid_i && (w_trig || (r_state == BURST));
    w_last_word = (r_word_ct == LAST_WORD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask       <= 2'b00;
      r_word_ct    <= '0;
      r_burst_ct   <= '0;
      r_bad_ct     <= '0;
      r_burst_left <= '0;
      r_gap_left   <= '0;
    end else if (w_start) begin
      r_mask       <= err_mask_i;
      r_word_ct    <= '0;
      r_burst_ct   <= '0;
      r_bad_ct     <= '0;
      r_burst_left <= '0;
      r_gap_left   <= GAP_INIT;
    end else if (w_step) begin
      r_word_ct <= r_word_ct + CNT_W'(1);
      if (w_trig) begin
        r_burst_ct   <= sat_add(r_burst_ct, 2'd1);
        r_burst_left <= BURST_INIT;
      end else if (r_state == BURST) begin
        r_burst_left <= r_burst_left - CNT_W'(1);
      end
      // Reloaded outside GUARD so the gap count is ready whenever GUARD is entered.
      if (r_state == GUARD) begin
        r_gap_left <= r_gap_left - CNT_W'(1);
      end else begin
        r_gap_left <= GAP_INIT;
      end
      if (w_corrupt) r_bad_ct <= sat_add(r_bad_ct, popcount2(r_mask));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dec_en  <= 1'b0;
      r_dec_sym <= 2'b00;
      r_inj     <= 1'b0;
    end else begin
      r_dec_en <= enc_valid_i;
      r_inj    <= w_corrupt;
      if (enc_valid_i) r_dec_sym <= enc_sym_i ^ (w_corrupt ? r_mask : 2'b00);
    end
  end

  assign dec_enable_o = r_dec_en;
  assign dec_sym_o    = r_dec_sym;
  assign inj_active_o = r_inj;
  assign busy_o       = w_active;
  assign done_o       = (r_state == DONE);
  assign word_ct_o    = r_word_ct;
  assign burst_ct_o   = r_burst_ct;
  assign bad_bit_ct_o = r_bad_ct;

endmodule
